// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - control-flow sequencer driving the PLC program counter load port
module pc_sequencer #(
  parameter int DEPTH     = 4,
  parameter int WDT_LIMIT = 1000,
  parameter int SCW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run_en,
  input  logic           instr_valid,
  input  logic [2:0]     op,
  input  logic [7:0]     target,
  input  logic           flag_z,
  input  logic [7:0]     pc,
  output logic           jmp_en,
  output logic [7:0]     jump_addr,
  output logic [1:0]     state,
  output logic           scan_done,
  output logic [SCW-1:0] scan_cnt,
  output logic [4:0]     sp,
  output logic [1:0]     err_code
);

  localparam int WW = $clog2(WDT_LIMIT + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_LIMIT - 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_END  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10,
    S_ERROR  = 2'b11
  } st_t;

  st_t           st;
  logic [WW-1:0] wdt;
  logic [7:0]    halt_addr;
  logic [7:0]    stk [16];

  logic       run_cmd;
  logic       stk_full;
  logic       stk_empty;
  logic       wdt_expire;
  logic [3:0] top_idx;
  logic [7:0] ret_addr;
  logic [7:0] top_entry;

  assign run_cmd    = (st == S_RUN) && instr_valid;
  assign stk_full   = (sp == 5'(DEPTH));
  assign stk_empty  = (sp == 5'd0);
  assign wdt_expire = (wdt == WDT_LAST);
  assign top_idx    = 4'(sp - 5'd1);
  assign ret_addr   = pc + 8'd1;
  assign top_entry  = stk[top_idx];
  assign state      = st;

  // Redirect decode: combinational so the counter sees it on its very next load.
  always_comb begin
    jmp_en    = 1'b1;
    jump_addr = 8'h00;
    case (st)
      S_IDLE: begin
        jmp_en    = 1'b1;
        jump_addr = 8'h00;
      end
      S_RUN: begin
        if (!instr_valid) begin
          jmp_en    = 1'b1;
          jump_addr = pc;
        end else begin
          case (op)
            OP_JMP: begin
              jmp_en    = 1'b1;
              jump_addr = target;
            end
            OP_JZ: begin
              jmp_en    = flag_z;
              jump_addr = target;
            end
            OP_CALL: begin
              jmp_en    = 1'b1;
              jump_addr = stk_full ? pc : target;
            end
            OP_RET: begin
              jmp_en    = 1'b1;
              jump_addr = stk_empty ? pc : top_entry;
            end
            OP_END: begin
              jmp_en    = 1'b1;
              jump_addr = 8'h00;
            end
            OP_HALT: begin
              jmp_en    = 1'b1;
              jump_addr = pc;
            end
            default: begin
              jmp_en    = 1'b0;
              jump_addr = pc;
            end
          endcase
        end
      end
      S_HALTED: begin
        jmp_en    = 1'b1;
        jump_addr = halt_addr;
      end
      default: begin
        jmp_en    = 1'b1;
        jump_addr = 8'h00;
      end
    endcase
  end

  // Return-address storage; entries beyond sp are stale and never read.
  always_ff @(posedge clk) begin
    if (run_cmd && (op == OP_CALL) && !stk_full) begin
      stk[sp[3:0]] <= ret_addr;
    end
  end

  // Run/halt/error FSM with stack pointer, scan bookkeeping and watchdog.
  // Instruction faults win over a watchdog expiry in the same cycle; END
  // always resets the watchdog so it can never expire on an END cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      sp        <= 5'd0;
      scan_cnt  <= '0;
      scan_done <= 1'b0;
      err_code  <= 2'b00;
      wdt       <= '0;
      halt_addr <= 8'h00;
    end else begin
      scan_done <= 1'b0;
      case (st)
        S_IDLE: begin
          wdt <= '0;
          if (run_en) begin
            st <= S_RUN;
          end
        end
        S_RUN: begin
          if (instr_valid && (op == OP_END)) begin
            sp        <= 5'd0;
            wdt       <= '0;
            scan_cnt  <= scan_cnt + SCW'(1);
            scan_done <= 1'b1;
            if (!run_en) begin
              st <= S_IDLE;
            end
          end else if (instr_valid && (op == OP_CALL) && stk_full) begin
            st       <= S_ERROR;
            err_code <= 2'b01;
            wdt      <= '0;
          end else if (instr_valid && (op == OP_RET) && stk_empty) begin
            st       <= S_ERROR;
            err_code <= 2'b10;
            wdt      <= '0;
          end else if (wdt_expire) begin
            st       <= S_ERROR;
            err_code <= 2'b11;
            wdt      <= '0;
          end else begin
            wdt <= wdt + WW'(1);
            if (instr_valid) begin
              case (op)
                OP_CALL: sp <= sp + 5'd1;
                OP_RET:  sp <= sp - 5'd1;
                OP_HALT: begin
                  halt_addr <= pc;
                  st        <= S_HALTED;
                  wdt       <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        S_HALTED: begin
          wdt <= '0;
          if (!run_en) begin
            st <= S_IDLE;
          end
        end
        default: begin
          wdt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

  localparam int DEPTH = 4;
  localparam int WDT   = 20;
  localparam int SCW   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           run_en = 1'b0;
  logic           instr_valid = 1'b0;
  logic [2:0]     op = 3'd0;
  logic [7:0]     target = 8'h00;
  logic           flag_z = 1'b0;
  logic [7:0]     pc = 8'h00;
  logic           jmp_en;
  logic [7:0]     jump_addr;
  logic [1:0]     state;
  logic           scan_done;
  logic [SCW-1:0] scan_cnt;
  logic [4:0]     sp;
  logic [1:0]     err_code;

  pc_sequencer #(.DEPTH(DEPTH), .WDT_LIMIT(WDT), .SCW(SCW)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .instr_valid(instr_valid), .op(op),
    .target(target), .flag_z(flag_z), .pc(pc), .jmp_en(jmp_en), .jump_addr(jump_addr),
    .state(state), .scan_done(scan_done), .scan_cnt(scan_cnt), .sp(sp), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 run, 2 halted, 3 error.
  int m_mode, m_scan, m_done, m_err, m_wdt, m_halt;
  int m_q[$];
  int err_cycles;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_scan = 0; m_done = 0; m_err = 0; m_wdt = 0; m_halt = 0;
    m_q.delete();
  endtask

  task automatic compare_all();
    int e_en, e_addr;
    e_en = 1; e_addr = 0;
    if (m_mode == 1) begin
      if (!instr_valid) e_addr = pc;
      else case (op)
        3'd1: e_addr = target;
        3'd2: begin e_en = flag_z; e_addr = target; end
        3'd3: e_addr = (m_q.size() == DEPTH) ? int'(pc) : int'(target);
        3'd4: e_addr = (m_q.size() == 0) ? int'(pc) : m_q[$];
        3'd5: e_addr = 0;
        3'd6: e_addr = pc;
        default: e_en = 0;
      endcase
    end else if (m_mode == 2) begin
      e_addr = m_halt;
    end
    check("jmp_en", jmp_en, e_en);
    if (e_en == 1) check("jump_addr", jump_addr, e_addr);
    check("state", state, m_mode);
    check("sp", sp, m_q.size());
    check("scan_cnt", scan_cnt, m_scan);
    check("scan_done", scan_done, m_done);
    check("err_code", err_code, m_err);
  endtask

  task automatic model_update();
    int nmode;
    nmode = m_mode;
    m_done = 0;
    case (m_mode)
      0: if (run_en) nmode = 1;
      1: begin
        if (instr_valid && op == 3'd5) begin
          m_q.delete();
          m_wdt = 0;
          m_scan = (m_scan + 1) % (1 << SCW);
          m_done = 1;
          if (!run_en) nmode = 0;
        end else if (instr_valid && op == 3'd3 && m_q.size() == DEPTH) begin
          nmode = 3; m_err = 1;
        end else if (instr_valid && op == 3'd4 && m_q.size() == 0) begin
          nmode = 3; m_err = 2;
        end else if (m_wdt + 1 >= WDT) begin
          nmode = 3; m_err = 3;
        end else begin
          m_wdt++;
          if (instr_valid && op == 3'd3) m_q.push_back((int'(pc) + 1) % 256);
          if (instr_valid && op == 3'd4) void'(m_q.pop_back());
          if (instr_valid && op == 3'd6) begin m_halt = pc; nmode = 2; end
        end
      end
      2: if (!run_en) nmode = 0;
      default: ;
    endcase
    if (nmode != 1) m_wdt = 0;
    m_mode = nmode;
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_state", state, 0);
    check("async_rst_sp", sp, 0);
    check("async_rst_err", err_code, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [2:0] o, input logic [7:0] p, input logic [7:0] t);
    instr_valid = v; op = o; pc = p; target = t;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state, 0);
    check("reset_jmp_en", jmp_en, 1);
    check("reset_addr", jump_addr, 0);
    check("reset_scan_done", scan_done, 0);
    rst = 1'b0;

    run_en = 1'b1;
    #1;
    check("idle_addr", jump_addr, 0);
    step();
    check("enter_run", state, 1);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 3'd0, 8'(i), 8'h00);
      #1;
      check("nop_jmp_en", jmp_en, 0);
      step();
    end

    set_in(1'b1, 3'd3, 8'h10, 8'h40); #1;
    check("call_addr", jump_addr, 8'h40);
    step();
    check("call_sp", sp, 1);
    set_in(1'b1, 3'd4, 8'h42, 8'h00); #1;
    check("ret_addr", jump_addr, 8'h11);
    step();
    check("ret_sp", sp, 0);
    set_in(1'b1, 3'd3, 8'hFF, 8'h80); step();
    set_in(1'b1, 3'd4, 8'h81, 8'h00); #1;
    check("ret_wrap_addr", jump_addr, 8'h00);
    step();

    flag_z = 1'b0; set_in(1'b1, 3'd2, 8'h05, 8'h20); #1;
    check("jz_not_taken", jmp_en, 0);
    step();
    flag_z = 1'b1; #1;
    check("jz_taken_en", jmp_en, 1);
    check("jz_taken_addr", jump_addr, 8'h20);
    step();

    set_in(1'b1, 3'd5, 8'h21, 8'h00); #1;
    check("end_addr", jump_addr, 0);
    step();
    check("scan_done_pulse", scan_done, 1);
    check("scan_cnt_one", scan_cnt, 1);
    check("end_stay_run", state, 1);
    set_in(1'b1, 3'd0, 8'h00, 8'h00); step();
    check("scan_done_clear", scan_done, 0);
    run_en = 1'b0;
    repeat (3) step();
    check("run_drop_midscan", state, 1);
    set_in(1'b1, 3'd5, 8'h04, 8'h00); step();
    check("end_to_idle", state, 0);

    run_en = 1'b1; set_in(1'b0, 3'd0, 8'h00, 8'h00); step();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 3'd3, 8'(8'h30 + i), 8'(8'h50 + i));
      #1;
      if (i == 4) check("ovf_hold_addr", jump_addr, 8'h34);
      step();
    end
    check("ovf_state", state, 3);
    check("ovf_err", err_code, 1);
    set_in(1'b1, 3'd4, 8'h60, 8'h00); #1;
    check("err_addr", jump_addr, 0);
    step();
    check("err_sticky", err_code, 1);
    do_reset();

    set_in(1'b0, 3'd0, 8'h00, 8'h00); step();
    set_in(1'b1, 3'd4, 8'h05, 8'h00); #1;
    check("unf_addr", jump_addr, 8'h05);
    step();
    check("unf_err", err_code, 2);
    do_reset();

    set_in(1'b0, 3'd0, 8'h00, 8'h00); step();
    set_in(1'b1, 3'd6, 8'h33, 8'h00); step();
    check("halted_state", state, 2);
    set_in(1'b1, 3'd0, 8'h50, 8'h00); #1;
    check("halted_addr", jump_addr, 8'h33);
    step();
    run_en = 1'b0; step();
    check("halt_to_idle", state, 0);

    run_en = 1'b1; set_in(1'b0, 3'd0, 8'h00, 8'h00); step();
    set_in(1'b1, 3'd0, 8'h00, 8'h00);
    repeat (WDT - 1) step();
    check("wdt_not_yet", state, 1);
    step();
    check("wdt_state", state, 3);
    check("wdt_err", err_code, 3);
    do_reset();

    set_in(1'b0, 3'd0, 8'h00, 8'h00); step();
    set_in(1'b1, 3'd5, 8'h00, 8'h00);
    repeat ((1 << SCW) - 1) step();
    check("scan_cnt_max", scan_cnt, (1 << SCW) - 1);
    step();
    check("scan_cnt_wrap", scan_cnt, 0);

    err_cycles = 0;
    for (int n = 0; n < 4000; n++) begin
      if (m_mode == 3) err_cycles++;
      else err_cycles = 0;
      if ($urandom_range(0, 299) == 0 || err_cycles > 6) begin
        do_reset();
        err_cycles = 0;
      end
      run_en      = ($urandom_range(0, 9) != 0);
      instr_valid = ($urandom_range(0, 4) != 0);
      op          = 3'($urandom_range(0, 7));
      pc          = 8'($urandom_range(0, 255));
      target      = 8'($urandom_range(0, 255));
      flag_z      = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control-flow sequencer for the 8-bit program counter of the PLC core.
- Decodes control-class instructions and drives the counter's jump-enable and jump-address inputs.
- Owns a call/return stack, scan-cycle handling (END restarts the program at address 0), a watchdog and the run/halt/error state.
- Sits between the instruction decoder and the program counter. While held, it drives the current PC back as the jump address so the counter stays in place.

Parameters:
- DEPTH, 4, number of return-address stack entries (1..16).
- WDT_LIMIT, 1000, maximum RUN-state cycles between two END instructions before a watchdog error.
- SCW, 16, width of the scan counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run_en  in  1  operator run request.
- instr_valid  in  1  op/target valid this cycle.
- op  in  3  control opcode: 000 NOP, 001 JMP, 010 JZ, 011 CALL, 100 RET, 101 END, 110 HALT, 111 reserved (treated as NOP).
- target  in  8  jump/call destination.
- flag_z  in  1  zero flag from the ALU.
- pc  in  8  current program counter value.
- jmp_en  out  1  load enable to the program counter.
- jump_addr  out  8  address loaded when jmp_en=1.
- state  out  2  00 IDLE, 01 RUN, 10 HALTED, 11 ERROR.
- scan_done  out  1  one-cycle pulse after each END.
- scan_cnt  out  SCW  completed scans, wraps at 2^SCW-1 -> 0.
- sp  out  5  stack fill level, 0..DEPTH.
- err_code  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 watchdog.

Behaviour:
- Reset (async, rst=1): state=IDLE, sp=0, scan_cnt=0, scan_done=0, err_code=00, watchdog=0, halt address register=0. Combinational outputs then give jmp_en=1, jump_addr=0.
- jmp_en and jump_addr are combinational from registered state plus the current inputs, so the redirect takes effect on the counter's next load. No added latency.
- IDLE: jmp_en=1, jump_addr=0. When run_en=1, go to RUN on the next edge.
- RUN, instr_valid=0: jmp_en=1, jump_addr=pc (stall hold). Watchdog still counts.
- RUN, instr_valid=1, decode:
  - NOP/111: jmp_en=0.
  - JMP: jmp_en=1, jump_addr=target.
  - JZ: jmp_en=flag_z, jump_addr=target.
  - CALL: push pc+1 (8-bit wrap, 255 -> 0), sp+1, jump to target. If sp==DEPTH: no push, jmp_en=1, jump_addr=pc, go to ERROR with err_code=01.
  - RET: pop, sp-1, jmp_en=1, jump_addr=top entry. If sp==0: jump_addr=pc, go to ERROR with err_code=10.
  - END: jmp_en=1, jump_addr=0; sp cleared to 0; watchdog cleared; scan_cnt+1; scan_done=1 on the following cycle. If run_en=0 at END, go to IDLE; otherwise stay in RUN. run_en deassertion mid-scan has no effect until END.
  - HALT: capture pc in the halt register, go to HALTED, jmp_en=1, jump_addr=pc.
- HALTED: jmp_en=1, jump_addr=halt register. When run_en=0, go to IDLE; run_en must then rise again to re-enter RUN from address 0.
- ERROR: jmp_en=1, jump_addr=0. Sticky; only rst exits. err_code holds the first error; later events are ignored.
- Watchdog: counts RUN cycles. When it reaches WDT_LIMIT without an END, go to ERROR with err_code=11. It is held at 0 outside RUN.
- Stack is LIFO, 8-bit entries. Push and pop never both occur in one cycle because op selects exactly one.
- instr_valid is ignored outside RUN.
- Reset asserted mid-operation overrides everything within the same cycle, asynchronously.

Test Plan:
- Reset, run_en=1, 5 NOP cycles -> state IDLE then RUN; jmp_en=1/jump_addr=0 in IDLE; jmp_en=0 during NOPs.
- pc=0x10 CALL target=0x40, then pc=0x42 RET -> jump_addr=0x40 with sp=1, then jump_addr=0x11 with sp=0. Also pc=0xFF CALL then RET -> return address 0x00.
- DEPTH=4: five nested CALLs -> fifth gives ERROR, err_code=01, jump_addr=0 thereafter. RET with sp=0 after reset -> err_code=10.
- JZ target=0x20 with flag_z=0 then 1 -> jmp_en 0 then 1, jump_addr=0x20.
- END with run_en=1 -> jump_addr=0, scan_done pulses one cycle later, scan_cnt=1, state RUN. Drop run_en mid-scan -> stays RUN until the next END, then IDLE.
- HALT at pc=0x33 -> HALTED with jump_addr=0x33. Then WDT_LIMIT=20 with no END in RUN -> ERROR, err_code=11 at cycle 20. Asserting rst mid-ERROR -> immediate IDLE.
